// File: rtl/condicionador_botoes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : condicionador_botoes_pkg
// Desc     : Shared state codes and debug-display width for the button
//            conditioning stage.
// Revision : 1.0 - initial release
// ============================================================================
package condicionador_botoes_pkg;

    localparam int c_estado_w    = 3;
    localparam int c_db_estado_w = 4;

    localparam logic [c_estado_w-1:0] c_ocioso            = 3'd0;
    localparam logic [c_estado_w-1:0] c_filtrando         = 3'd1;
    localparam logic [c_estado_w-1:0] c_valido            = 3'd2;
    localparam logic [c_estado_w-1:0] c_aguarda_soltar    = 3'd3;
    localparam logic [c_estado_w-1:0] c_filtrando_soltura = 3'd4;

endpackage
`default_nettype wire

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_2ff
// Desc     : Per-bit two-flop synchronizer with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA-1:0] i_d,
    output logic [LARGURA-1:0] o_q
);

    logic [LARGURA-1:0] r_meta;
    logic [LARGURA-1:0] r_sinc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sinc <= '0;
        end else begin
            r_meta <= i_d;
            r_sinc <= r_meta;
        end
    end

    assign o_q = r_sinc;

endmodule
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module   : condicionador_botoes
// Desc     : Debounces raw buttons, validates presses and enforces
//            press/release discipline. Macro CONDICIONADOR_SINCRONIZADOR_EN
//            inserts a 2-flop synchronizer ahead of the FSM.
// Revision : 1.0 - initial release
// ============================================================================
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CW              = $clog2(DEBOUNCE_CICLOS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_BOTOES-1:0]      botoes_brutos,
    input  logic                     habilita,
    output logic                     jogada_pulso,
    output logic                     multiplo,
    output logic [N_BOTOES-1:0]      botoes_reg,
    output logic                     botao_ativo,
    output logic [c_db_estado_w-1:0] db_estado
);

    localparam logic [CW-1:0] c_cont_max = CW'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0]   w_s;
    logic [c_estado_w-1:0] r_estado;
    logic [c_estado_w-1:0] w_prox_estado;
    logic [CW-1:0]         r_contador;
    logic [CW-1:0]         w_prox_contador;
    logic [N_BOTOES-1:0]   r_candidato;
    logic [N_BOTOES-1:0]   w_prox_candidato;
    logic [N_BOTOES-1:0]   r_botoes_reg;
    logic                  w_carrega_reg;

`ifdef CONDICIONADOR_SINCRONIZADOR_EN
    sincronizador_2ff #(
        .LARGURA (N_BOTOES)
    ) u_sincronizador (
        .clk (clock),
        .rst (reset),
        .i_d (botoes_brutos),
        .o_q (w_s)
    );
`else
    assign w_s = botoes_brutos;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= c_ocioso;
            r_contador   <= '0;
            r_candidato  <= '0;
            r_botoes_reg <= '0;
        end else begin
            r_estado    <= w_prox_estado;
            r_contador  <= w_prox_contador;
            r_candidato <= w_prox_candidato;
            if (w_carrega_reg) begin
                r_botoes_reg <= r_candidato;
            end
        end
    end

    // The counter is cleared on every entry to a filter state and stops at
    // c_cont_max, so it can never wrap.
    always_comb begin
        w_prox_estado    = r_estado;
        w_prox_contador  = r_contador;
        w_prox_candidato = r_candidato;
        w_carrega_reg    = 1'b0;
        case (r_estado)
            c_ocioso: begin
                if (habilita && (w_s != '0)) begin
                    w_prox_candidato = w_s;
                    w_prox_contador  = '0;
                    w_prox_estado    = c_filtrando;
                end
            end
            c_filtrando: begin
                if (!habilita || (w_s != r_candidato)) begin
                    w_prox_estado = c_ocioso;
                end else if (r_contador == c_cont_max) begin
                    w_prox_estado = c_valido;
                    w_carrega_reg = 1'b1;
                end else begin
                    w_prox_contador = r_contador + CW'(1);
                end
            end
            c_valido: begin
                w_prox_estado = c_aguarda_soltar;
            end
            c_aguarda_soltar: begin
                if (w_s == '0) begin
                    w_prox_contador = '0;
                    w_prox_estado   = c_filtrando_soltura;
                end
            end
            c_filtrando_soltura: begin
                if (w_s != '0) begin
                    w_prox_estado = c_aguarda_soltar;
                end else if (r_contador == c_cont_max) begin
                    w_prox_estado = c_ocioso;
                end else begin
                    w_prox_contador = r_contador + CW'(1);
                end
            end
            default: begin
                w_prox_estado = c_ocioso;
            end
        endcase
    end

    always_comb begin
        jogada_pulso = 1'b0;
        multiplo     = 1'b0;
        botao_ativo  = 1'b0;
        case (r_estado)
            c_valido: begin
                jogada_pulso = $onehot(r_candidato);
                multiplo     = (r_candidato != '0) && !$onehot(r_candidato);
                botao_ativo  = 1'b1;
            end
            c_aguarda_soltar, c_filtrando_soltura: begin
                botao_ativo = 1'b1;
            end
            default: begin
                botao_ativo = 1'b0;
            end
        endcase
    end

    assign botoes_reg = r_botoes_reg;
    assign db_estado  = c_db_estado_w'(r_estado);

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module   : tb_condicionador_botoes
// Desc     : Directed and random stimulus against a cycle-timestamp reference
//            model of the button conditioner (DEBOUNCE_CICLOS = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes_brutos;
    logic       jogada_pulso;
    logic       multiplo;
    logic [3:0] botoes_reg;
    logic       botao_ativo;
    logic [3:0] db_estado;

    int n_vec = 0;
    int n_err = 0;
    int ciclo = 0;

    // Reference model: phase code, timestamp of the last filter start,
    // candidate and last validated code.
    int         m_fase = 0;
    int         m_t0   = 0;
    logic [3:0] m_cand = '0;
    logic [3:0] m_reg  = '0;

    int n_pulsos  = 0;
    int n_mult    = 0;
    int ult_pulso = -1;
    int s0        = 0;

    condicionador_botoes #(
        .N_BOTOES        (4),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes_brutos (botoes_brutos),
        .habilita      (habilita),
        .jogada_pulso  (jogada_pulso),
        .multiplo      (multiplo),
        .botoes_reg    (botoes_reg),
        .botao_ativo   (botao_ativo),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, ciclo, obs, exp);
        end
    endtask

    task automatic confere();
        logic valido;
        valido = (m_fase == 2);
        verifica("jogada_pulso", 32'(jogada_pulso), 32'(valido && ($countones(m_cand) == 1)));
        verifica("multiplo",     32'(multiplo),     32'(valido && ($countones(m_cand) >= 2)));
        verifica("botao_ativo",  32'(botao_ativo),  32'(m_fase >= 2 && m_fase <= 4));
        verifica("botoes_reg",   32'(botoes_reg),   32'(m_reg));
        verifica("db_estado",    32'(db_estado),    32'(m_fase));
        if (jogada_pulso === 1'b1) begin
            n_pulsos++;
            ult_pulso = ciclo;
        end
        if (multiplo === 1'b1) n_mult++;
    endtask

    // A press is accepted after D further cycles matching the candidate;
    // a release after D further all-zero cycles.
    task automatic modelo(input logic [3:0] s, input bit h, input bit r);
        if (r) begin
            m_fase = 0;
            m_cand = '0;
            m_reg  = '0;
        end else if (m_fase == 0) begin
            if (h && s != 0) begin
                m_cand = s;
                m_t0   = ciclo;
                m_fase = 1;
            end
        end else if (m_fase == 1) begin
            if (!h || s != m_cand)      m_fase = 0;
            else if (ciclo - m_t0 == D) begin
                m_fase = 2;
                m_reg  = m_cand;
            end
        end else if (m_fase == 2) begin
            m_fase = 3;
        end else if (m_fase == 3) begin
            if (s == 0) begin
                m_t0   = ciclo;
                m_fase = 4;
            end
        end else begin
            if (s != 0)                 m_fase = 3;
            else if (ciclo - m_t0 == D) m_fase = 0;
        end
    endtask

    task automatic passo(input logic [3:0] b, input bit h, input bit r);
        @(negedge clock);
        confere();
        botoes_brutos = b;
        habilita      = h;
        reset         = r;
        modelo(b, h, r);
        ciclo++;
    endtask

    task automatic zera_contagem();
        n_pulsos  = 0;
        n_mult    = 0;
        ult_pulso = -1;
    endtask

    initial begin
        reset         = 1'b1;
        habilita      = 1'b0;
        botoes_brutos = '0;
        @(posedge clock);
        passo(4'b0000, 1'b0, 1'b1);
        passo(4'b0000, 1'b1, 1'b0);

        // Clean press
        repeat (3) passo(4'b0000, 1'b1, 1'b0);
        zera_contagem();
        s0 = ciclo;
        repeat (20) passo(4'b0100, 1'b1, 1'b0);
        repeat (10) passo(4'b0000, 1'b1, 1'b0);
        verifica("s1_latency", 32'(ult_pulso - s0), 32'd5);
        verifica("s1_pulses",  32'(n_pulsos), 32'd1);
        verifica("s1_reg",     32'(botoes_reg), 32'h4);

        // Bounce before a stable press
        zera_contagem();
        repeat (2) passo(4'b0001, 1'b1, 1'b0);
        passo(4'b0000, 1'b1, 1'b0);
        s0 = ciclo;
        repeat (10) passo(4'b0001, 1'b1, 1'b0);
        repeat (8) passo(4'b0000, 1'b1, 1'b0);
        verifica("s2_latency", 32'(ult_pulso - s0), 32'd5);
        verifica("s2_pulses",  32'(n_pulsos), 32'd1);

        // Two buttons together
        zera_contagem();
        repeat (10) passo(4'b0011, 1'b1, 1'b0);
        repeat (8) passo(4'b0000, 1'b1, 1'b0);
        verifica("s3_mult",   32'(n_mult), 32'd1);
        verifica("s3_pulses", 32'(n_pulsos), 32'd0);
        verifica("s3_reg",    32'(botoes_reg), 32'h3);

        // Hold, add a button, short release, re-press
        zera_contagem();
        repeat (8) passo(4'b1000, 1'b1, 1'b0);
        repeat (4) passo(4'b1010, 1'b1, 1'b0);
        repeat (2) passo(4'b0000, 1'b1, 1'b0);
        passo(4'b1010, 1'b1, 1'b0);
        repeat (8) passo(4'b0000, 1'b1, 1'b0);
        verifica("s4_pulses", 32'(n_pulsos), 32'd1);
        verifica("s4_estado", 32'(db_estado), 32'd0);

        // Presses ignored while disabled, accepted once enabled
        zera_contagem();
        repeat (6) passo(4'b0100, 1'b0, 1'b0);
        verifica("s5_disabled", 32'(n_pulsos), 32'd0);
        s0 = ciclo;
        repeat (10) passo(4'b0100, 1'b1, 1'b0);
        repeat (8) passo(4'b0000, 1'b1, 1'b0);
        verifica("s5_latency", 32'(ult_pulso - s0), 32'd5);

        // Reset while filtering, then while waiting for release
        repeat (3) passo(4'b0001, 1'b1, 1'b0);
        passo(4'b0001, 1'b1, 1'b1);
        passo(4'b0000, 1'b1, 1'b0);
        repeat (9) passo(4'b0010, 1'b1, 1'b0);
        passo(4'b0010, 1'b1, 1'b1);
        repeat (8) passo(4'b0000, 1'b1, 1'b0);

        // Random bursts of held patterns
        repeat (160) begin
            int         sel;
            int         dur;
            logic [3:0] b;
            bit         h;
            sel = $urandom_range(0, 9);
            if (sel < 2)      b = 4'b0000;
            else if (sel < 6) b = 4'(1 << $urandom_range(0, 3));
            else              b = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 8);
            h   = ($urandom_range(0, 7) != 0);
            repeat (dur) passo(b, h, 1'b0);
            if ($urandom_range(0, 39) == 0) passo(b, h, 1'b1);
        end
        passo(4'b0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
